// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding
// and parameter defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_REQ  = 2'd1,
        MD_WAIT = 2'd2,
        HALT    = 2'd3
    } pipe_state_e;

    localparam int unsigned MD_MAX_WAIT_DEF = 32;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module pipe_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/bubble sequencer with mul/div handshake and watchdog.
// Define PIPE_STALL_CNT_EN to build the stall/flush performance counters.
//
// state   | meaning
// RUN     | normal flow; hazards decoded combinationally
// MD_REQ  | pipeline held, md_req asserted until md_ack
// MD_WAIT | pipeline held, waiting for md_done
// HALT    | pipeline frozen for debug, halt_ack high
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_MAX_WAIT = MD_MAX_WAIT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken_EX,
    input  logic             md_op_EX,
    input  logic             md_ack,
    input  logic             md_done,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             md_req,
    output logic             halt_ack,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] WD_LAST = 8'(MD_MAX_WAIT - 1);

    pipe_state_e state_q, state_d;
    logic [7:0]  wd_cnt;
    logic        md_req_q;
    logic        md_timeout_q;
    logic        timeout_set;
    logic        md_release;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wd_cnt       <= 8'd0;
            md_req_q     <= 1'b0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_req_q     <= (state_d == MD_REQ);
            md_timeout_q <= md_timeout_q | timeout_set;
            if (state_q == RUN && state_d == MD_REQ) begin
                wd_cnt <= 8'd0;
            end else if (state_q == MD_REQ || state_q == MD_WAIT) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        halt_ack     = 1'b0;
        timeout_set  = 1'b0;
        md_release   = 1'b0;

        case (state_q)
            RUN: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                if (halt_req) begin
                    state_d = HALT;
                end else if (branch_taken_EX) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (md_op_EX) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    state_d      = MD_REQ;
                end else if (load_use_stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_REQ, MD_WAIT: begin
                exmem_en     = 1'b1;
                exmem_bubble = 1'b1;
                // In MD_REQ a done only counts when the unit also acknowledges.
                md_release   = md_done && (state_q == MD_WAIT || md_ack);
                if (md_release) begin
                    pc_en        = 1'b1;
                    ifid_en      = 1'b1;
                    idex_en      = 1'b1;
                    exmem_bubble = 1'b0;
                    state_d      = halt_req ? HALT : RUN;
                end else if (wd_cnt == WD_LAST) begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = RUN;
                end else if (state_q == MD_REQ && md_ack) begin
                    state_d = MD_WAIT;
                end
            end
            HALT: begin
                halt_ack = 1'b1;
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            halt_ack     = 1'b0;
        end
    end

    assign md_req     = md_req_q & rst_n;
    assign md_timeout = md_timeout_q;

`ifdef PIPE_STALL_CNT_EN
    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_en & rst_n),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stimulus pushes expected outputs to a
// scoreboard queue, a negedge monitor pops and compares each cycle.
module tb_pipe_stall_ctrl;

    localparam int CW = 16;

    // flag order: pc ifid idex exmem | ifid_flush idex_bubble exmem_bubble | md_req halt_ack md_timeout
    localparam logic [9:0] X_RST     = 10'b0000_000_000;
    localparam logic [9:0] X_NORM    = 10'b1111_000_000;
    localparam logic [9:0] X_LU      = 10'b0011_010_000;
    localparam logic [9:0] X_BR      = 10'b1111_110_000;
    localparam logic [9:0] X_MDOP    = 10'b0001_001_000;
    localparam logic [9:0] X_MDREQ   = 10'b0001_001_100;
    localparam logic [9:0] X_MDWAIT  = 10'b0001_001_000;
    localparam logic [9:0] X_REL     = 10'b1111_000_000;
    localparam logic [9:0] X_REL_REQ = 10'b1111_000_100;
    localparam logic [9:0] X_TO_WAIT = 10'b1111_001_000;
    localparam logic [9:0] X_TO_REQ  = 10'b1111_001_100;
    localparam logic [9:0] X_HALT    = 10'b0000_000_010;
    localparam logic [9:0] X_TO      = 10'b0000_000_001;

    typedef struct {
        logic [9:0]    flags;
        logic [CW-1:0] st;
        logic [CW-1:0] fl;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, load_use_stall, branch_taken_EX, md_op_EX, md_ack, md_done, halt_req;
    logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble;
    logic md_req, halt_ack, md_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] stall_m  = '0;
    logic [CW-1:0] flush_m  = '0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_MAX_WAIT(8), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_stall  (load_use_stall),
        .branch_taken_EX (branch_taken_EX),
        .md_op_EX        (md_op_EX),
        .md_ack          (md_ack),
        .md_done         (md_done),
        .halt_req        (halt_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .md_req          (md_req),
        .halt_ack        (halt_ack),
        .md_timeout      (md_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = sb_q.pop_front();
            got = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
                   exmem_bubble, md_req, halt_ack, md_timeout};
            n_checks++;
            if (got !== e.flags) begin
                n_fail++;
                $display("FAIL %s flags: got %b expected %b", e.name, got, e.flags);
            end
            n_checks++;
            if (stall_cnt !== e.st || flush_cnt !== e.fl) begin
                n_fail++;
                $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         e.name, stall_cnt, flush_cnt, e.st, e.fl);
            end
        end
    end

    task automatic step(input logic r, input logic lu, input logic br, input logic op,
                        input logic ack, input logic done, input logic hr,
                        input logic [9:0] f, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = r;
        load_use_stall  = lu;
        branch_taken_EX = br;
        md_op_EX        = op;
        md_ack          = ack;
        md_done         = done;
        halt_req        = hr;
        e.flags = f;
        e.name  = nm;
`ifdef PIPE_STALL_CNT_EN
        e.st = stall_m;
        e.fl = flush_m;
`else
        e.st = '0;
        e.fl = '0;
`endif
        sb_q.push_back(e);
        if (!r) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
            if (!f[9]) stall_m = stall_m + 1'b1;
            if (f[5])  flush_m = flush_m + 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; load_use_stall = 1'b0; branch_taken_EX = 1'b0;
        md_op_EX = 1'b0; md_ack = 1'b0; md_done = 1'b0; halt_req = 1'b0;

        //    rst lu br op ack dn hr  expected
        step(0, 0, 0, 0, 0, 0, 0, X_RST,  "reset0");
        step(0, 1, 1, 1, 0, 0, 1, X_RST,  "reset_inputs_masked");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM, "run_idle");
        step(1, 1, 0, 0, 0, 0, 0, X_LU,   "load_use");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM, "after_load_use");
        step(1, 1, 1, 0, 0, 0, 0, X_BR,   "lu_and_branch");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM, "after_branch");

        // md_op at t, ack at t+1, done at t+4
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP,   "md_op_t0");
        step(1, 0, 0, 1, 1, 0, 0, X_MDREQ,  "md_req_ack_t1");
        step(1, 0, 0, 1, 0, 0, 0, X_MDWAIT, "md_wait_t2");
        step(1, 0, 0, 1, 0, 0, 0, X_MDWAIT, "md_wait_t3");
        step(1, 0, 0, 1, 0, 1, 0, X_REL,    "md_release_t4");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM,   "after_md_release");

        // ack and done together in MD_REQ
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP,    "md_op_b");
        step(1, 0, 0, 0, 1, 1, 0, X_REL_REQ, "ack_done_same_cycle");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM,    "md_req_drop_after_ack_done");

        // watchdog expiry from MD_WAIT, hazards ignored while held
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP,   "md_op_c");
        step(1, 0, 0, 0, 1, 0, 0, X_MDREQ,  "wd_req_ack");
        step(1, 0, 1, 0, 0, 0, 0, X_MDWAIT, "wd_branch_ignored");
        step(1, 1, 0, 0, 0, 0, 0, X_MDWAIT, "wd_load_use_ignored");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, X_MDWAIT, "wd_wait");
        step(1, 0, 0, 0, 0, 0, 0, X_TO_WAIT,     "wd_expire_wait");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM | X_TO, "timeout_flag_set");
        step(1, 1, 0, 0, 0, 0, 0, X_LU | X_TO,   "timeout_sticky_lu");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM | X_TO, "timeout_sticky");

        // halt requested during MD_WAIT is honoured after md_done
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP | X_TO,   "halt_md_op");
        step(1, 0, 0, 0, 1, 0, 0, X_MDREQ | X_TO,  "halt_md_ack");
        step(1, 0, 0, 0, 0, 0, 1, X_MDWAIT | X_TO, "halt_in_md_wait");
        step(1, 0, 0, 0, 0, 1, 1, X_REL | X_TO,    "halt_md_done");
        step(1, 0, 0, 0, 0, 0, 1, X_HALT | X_TO,   "halt_frozen");
        step(1, 1, 1, 1, 0, 0, 1, X_HALT | X_TO,   "halt_frozen_inputs");
        step(1, 0, 0, 0, 0, 0, 0, X_HALT | X_TO,   "halt_req_low");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM | X_TO,   "halt_exit_run");

        // halt straight from RUN
        step(1, 0, 0, 0, 0, 0, 1, X_NORM | X_TO, "halt_from_run");
        step(1, 0, 0, 0, 0, 0, 0, X_HALT | X_TO, "halt_ack_one");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM | X_TO, "halt_back_run");

        // reset mid-handshake clears md_req and the sticky flag
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP | X_TO,  "rst_md_op");
        step(1, 0, 0, 0, 0, 0, 0, X_MDREQ | X_TO, "rst_in_md_req");
        step(0, 0, 0, 0, 0, 0, 0, X_RST | X_TO,   "rst_mid_handshake");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM,         "rst_back_run");

        // watchdog expiry while still waiting for md_ack
        step(1, 0, 0, 1, 0, 0, 0, X_MDOP, "wd2_md_op");
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0, X_MDREQ, "wd2_req");
        step(1, 0, 0, 0, 0, 0, 0, X_TO_REQ,      "wd2_expire_req");
        step(1, 0, 0, 0, 0, 0, 0, X_NORM | X_TO, "wd2_flag_set");

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
